// File: rtl/irq_ctrl_mmio.sv
// MMIO interrupt controller: latches per-source requests, gates them with an enable mask,
// drives one CPU interrupt line and runs a claim/complete handshake with per-source eoi pulses.
module irq_ctrl_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h8100_8000,
  parameter int          NUM_SRC   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic               mem_instr,
  output logic               mem_ready,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic [31:0]        mem_rdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [NUM_SRC-1:0] eoi,
  output logic               cpu_irq
);

  localparam logic [2:0] REG_PENDING  = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_CLAIM    = 3'd2;
  localparam logic [2:0] REG_COMPLETE = 3'd3;
  localparam logic [2:0] REG_EDGE     = 3'd4;
  localparam logic [2:0] REG_SW_SET   = 3'd5;
  localparam logic [2:0] REG_INSVC    = 3'd6;

  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] enable_reg, enable_next;
  logic [NUM_SRC-1:0] edge_reg, edge_next;
  logic [NUM_SRC-1:0] insvc_reg, insvc_next;
  logic [NUM_SRC-1:0] irq_src_q_reg;
  logic [NUM_SRC-1:0] eoi_reg;
  logic               cpu_irq_reg;
  logic               mem_ready_reg;
  logic [31:0]        mem_rdata_reg;
  logic               acc_done_reg, acc_done_next;

  logic [31:0] offset;
  logic        hit;
  logic        accept;
  logic        is_write;
  logic [2:0]  reg_sel;
  logic [31:0] wmask;
  logic [31:0] wr_masked;
  logic [NUM_SRC-1:0] wr_bits;
  logic [NUM_SRC-1:0] wm_bits;
  logic        claim_rd, complete_wr, enable_wr, edge_wr, sw_set_wr;
  logic [NUM_SRC-1:0] claim_cand;
  logic        claim_found;
  logic [4:0]  claim_idx;
  logic [4:0]  claim_id;
  logic [NUM_SRC-1:0] claim_onehot;
  logic [NUM_SRC-1:0] complete_onehot;
  logic [NUM_SRC-1:0] set_bits;
  logic [31:0] rd_value;
  logic        unused_bits;

  assign offset   = mem_addr - BASE_ADDR;
  assign hit      = mem_valid && !mem_instr && (offset[31:5] == '0);
  // acc_done holds off re-acceptance until the master drops mem_valid
  assign accept   = hit && !acc_done_reg;
  assign is_write = |mem_wstrb;
  assign reg_sel  = offset[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{mem_wstrb[gi]}};
    end
  endgenerate

  assign wr_masked = mem_wdata & wmask;
  assign wr_bits   = wr_masked[NUM_SRC-1:0];
  assign wm_bits   = wmask[NUM_SRC-1:0];

  assign claim_rd    = accept && !is_write && (reg_sel == REG_CLAIM);
  assign complete_wr = accept && is_write && (reg_sel == REG_COMPLETE);
  assign enable_wr   = accept && is_write && (reg_sel == REG_ENABLE);
  assign edge_wr     = accept && is_write && (reg_sel == REG_EDGE);
  assign sw_set_wr   = accept && is_write && (reg_sel == REG_SW_SET);

  assign claim_cand = pending_reg & enable_reg & ~insvc_reg;

  always_comb begin
    claim_found = 1'b0;
    claim_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (claim_cand[i]) begin
        claim_found = 1'b1;
        claim_idx   = 5'(i);
      end
    end
  end

  assign claim_id = claim_found ? claim_idx + 5'd1 : 5'd0;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign claim_onehot[gi]    = claim_rd && claim_found && (claim_idx == 5'(gi));
      assign complete_onehot[gi] = complete_wr && (wr_masked[4:0] == 5'(gi + 1)) && insvc_reg[gi];
      // Level mode treats a bit being claimed this edge as already in service
      assign set_bits[gi] = (edge_reg[gi] ? (irq_src[gi] & ~irq_src_q_reg[gi])
                                          : (irq_src[gi] & ~insvc_reg[gi] & ~claim_onehot[gi] & ~eoi_reg[gi]))
                          | (sw_set_wr & wr_bits[gi]);
      assign pending_next[gi] = set_bits[gi] | (pending_reg[gi] & ~claim_onehot[gi]);
    end
  endgenerate

  assign insvc_next    = (insvc_reg | claim_onehot) & ~complete_onehot;
  assign enable_next   = enable_wr ? ((enable_reg & ~wm_bits) | (wr_bits & wm_bits)) : enable_reg;
  assign edge_next     = edge_wr ? ((edge_reg & ~wm_bits) | (wr_bits & wm_bits)) : edge_reg;
  assign acc_done_next = mem_valid && (acc_done_reg || accept);

  always_comb begin
    rd_value = '0;
    case (reg_sel)
      REG_PENDING: rd_value[NUM_SRC-1:0] = pending_reg;
      REG_ENABLE:  rd_value[NUM_SRC-1:0] = enable_reg;
      REG_CLAIM:   rd_value[4:0]         = claim_id;
      REG_EDGE:    rd_value[NUM_SRC-1:0] = edge_reg;
      REG_INSVC:   rd_value[NUM_SRC-1:0] = insvc_reg;
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_reg   <= '0;
      enable_reg    <= '0;
      edge_reg      <= '0;
      insvc_reg     <= '0;
      irq_src_q_reg <= '0;
      eoi_reg       <= '0;
      cpu_irq_reg   <= 1'b0;
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= '0;
      acc_done_reg  <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      edge_reg      <= edge_next;
      insvc_reg     <= insvc_next;
      irq_src_q_reg <= irq_src;
      eoi_reg       <= complete_onehot;
      cpu_irq_reg   <= |claim_cand;
      mem_ready_reg <= accept;
      mem_rdata_reg <= (accept && !is_write) ? rd_value : '0;
      acc_done_reg  <= acc_done_next;
    end
  end

  assign mem_ready = mem_ready_reg;
  assign mem_rdata = mem_rdata_reg;
  assign eoi       = eoi_reg;
  assign cpu_irq   = cpu_irq_reg;

  assign unused_bits = ^{offset[1:0], wr_masked};

endmodule

// File: tb/tb_irq_ctrl_mmio.sv
// Directed testbench for irq_ctrl_mmio: edge/level claim-complete flows, priority,
// invalid completes, set-beats-clear, bus handshake corners and reset mid-operation.
module tb_irq_ctrl_mmio;

  localparam logic [31:0] BASE    = 32'h8100_8000;
  localparam int          NUM_SRC = 8;

  localparam logic [31:0] OFF_PENDING  = 32'h00;
  localparam logic [31:0] OFF_ENABLE   = 32'h04;
  localparam logic [31:0] OFF_CLAIM    = 32'h08;
  localparam logic [31:0] OFF_COMPLETE = 32'h0C;
  localparam logic [31:0] OFF_EDGE     = 32'h10;
  localparam logic [31:0] OFF_SW_SET   = 32'h14;
  localparam logic [31:0] OFF_INSVC    = 32'h18;
  localparam logic [31:0] OFF_RSVD     = 32'h1C;

  logic               clk;
  logic               resetn;
  logic               mem_valid;
  logic               mem_instr;
  logic               mem_ready;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wstrb;
  logic [31:0]        mem_rdata;
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] eoi;
  logic               cpu_irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_mmio #(.BASE_ADDR(BASE), .NUM_SRC(NUM_SRC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .irq_src   (irq_src),
    .eoi       (eoi),
    .cpu_irq   (cpu_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 one idle cycle after mem_ready.
  task automatic bus(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output logic [NUM_SRC-1:0] eoi_seen);
    logic got;
    got       = 1'b0;
    rd        = '0;
    eoi_seen  = '0;
    mem_addr  = BASE + off;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        got      = 1'b1;
        rd       = mem_rdata;
        eoi_seen = eoi;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    if (!got) check("bus_timeout", {31'b0, mem_ready}, 32'd1);
    $display("bus off=0x%02h wdata=0x%08h wstrb=%b rdata=0x%08h eoi=0x%02h", off[7:0], wd, ws, rd, eoi_seen);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd);
    logic [31:0] r;
    logic [NUM_SRC-1:0] e;
    bus(off, wd, 4'hF, r, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic [NUM_SRC-1:0] e;
    bus(off, 32'h0, 4'h0, r, e);
    check(tag, r, exp);
  endtask

  task automatic complete_chk(input string tag, input logic [31:0] id, input logic [31:0] exp_eoi);
    logic [31:0] r;
    logic [NUM_SRC-1:0] e;
    bus(OFF_COMPLETE, id, 4'hF, r, e);
    check(tag, {24'b0, e}, exp_eoi);
    check({tag, "_eoi_gone"}, {24'b0, eoi}, 32'h0);
  endtask

  task automatic ready_count(input string tag, input logic [31:0] addr, input logic instr,
                             input logic [31:0] exp);
    int cnt;
    cnt       = 0;
    mem_addr  = addr;
    mem_instr = instr;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ready) cnt++;
    end
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    $display("held access addr=0x%08h instr=%0d ready_cycles=%0d", addr, instr, cnt);
    check(tag, 32'(cnt), exp);
    @(posedge clk); #1;
  endtask

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    irq_src   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_eoi",   {24'b0, eoi}, 32'h0);
    check("rst_irq",   {31'b0, cpu_irq}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_pending", OFF_PENDING, 32'h0);
    rd_chk("rst_insvc",   OFF_INSVC,   32'h0);

    // Edge-mode source 1: pulse, claim, complete
    wr(OFF_ENABLE, 32'h1);
    wr(OFF_EDGE,   32'h1);
    irq_src = 8'h01;
    @(posedge clk); #1;
    check("edge_irq_lat0", {31'b0, cpu_irq}, 32'h0);
    irq_src = 8'h00;
    @(posedge clk); #1;
    check("edge_irq_lat1", {31'b0, cpu_irq}, 32'h1);
    rd_chk("edge_pending", OFF_PENDING, 32'h1);
    rd_chk("edge_claim",   OFF_CLAIM,   32'h1);
    check("edge_irq_drop", {31'b0, cpu_irq}, 32'h0);
    rd_chk("edge_insvc",   OFF_INSVC,   32'h1);
    complete_chk("edge_complete", 32'h1, 32'h1);
    rd_chk("edge_insvc_clr", OFF_INSVC, 32'h0);

    // Level-mode source 1 held high, drops when eoi is seen
    wr(OFF_EDGE, 32'h0);
    irq_src = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("lvl_irq", {31'b0, cpu_irq}, 32'h1);
    rd_chk("lvl_claim", OFF_CLAIM, 32'h1);
    check("lvl_irq_drop", {31'b0, cpu_irq}, 32'h0);
    rd_chk("lvl_pending_insvc", OFF_PENDING, 32'h0);
    begin
      logic [31:0] r;
      logic [NUM_SRC-1:0] e;
      bus(OFF_COMPLETE, 32'h1, 4'hF, r, e);
      check("lvl_eoi", {24'b0, e}, 32'h1);
      irq_src = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    check("lvl_irq_after", {31'b0, cpu_irq}, 32'h0);
    rd_chk("lvl_no_repend", OFF_PENDING, 32'h0);

    // Priority with a disabled lowest source
    wr(OFF_ENABLE, 32'h6);
    wr(OFF_SW_SET, 32'h7);
    check("prio_irq", {31'b0, cpu_irq}, 32'h1);
    rd_chk("prio_pending", OFF_PENDING, 32'h7);
    rd_chk("prio_claim_a", OFF_CLAIM, 32'h2);
    rd_chk("prio_claim_b", OFF_CLAIM, 32'h3);
    rd_chk("prio_claim_c", OFF_CLAIM, 32'h0);
    rd_chk("prio_insvc",   OFF_INSVC, 32'h6);
    check("prio_irq_off", {31'b0, cpu_irq}, 32'h0);
    rd_chk("prio_pending_left", OFF_PENDING, 32'h1);

    // Invalid completes, then the real ones
    complete_chk("cpl_id0", 32'h0, 32'h0);
    complete_chk("cpl_id9", 32'h9, 32'h0);
    complete_chk("cpl_id1_idle", 32'h1, 32'h0);
    rd_chk("cpl_insvc_kept", OFF_INSVC, 32'h6);
    complete_chk("cpl_id2", 32'h2, 32'h2);
    complete_chk("cpl_id3", 32'h3, 32'h4);
    rd_chk("cpl_insvc_clr", OFF_INSVC, 32'h0);

    // Edge on source 2 coincident with its claim
    wr(OFF_EDGE,   32'h2);
    wr(OFF_ENABLE, 32'h2);
    wr(OFF_SW_SET, 32'h2);
    rd_chk("sbc_pending_pre", OFF_PENDING, 32'h3);
    irq_src = 8'h02;
    rd_chk("sbc_claim", OFF_CLAIM, 32'h2);
    irq_src = 8'h00;
    rd_chk("sbc_pending", OFF_PENDING, 32'h3);
    rd_chk("sbc_insvc",   OFF_INSVC,   32'h2);
    check("sbc_irq_off", {31'b0, cpu_irq}, 32'h0);
    complete_chk("sbc_complete", 32'h2, 32'h2);
    check("sbc_irq_repend", {31'b0, cpu_irq}, 32'h1);
    rd_chk("sbc_claim2", OFF_CLAIM, 32'h2);
    complete_chk("sbc_complete2", 32'h2, 32'h2);

    // Bus handshake corners
    ready_count("held_ready", BASE + OFF_ENABLE, 1'b0, 32'd1);
    ready_count("oow_ready",  BASE + 32'h40,     1'b0, 32'd0);
    ready_count("instr_ready", BASE + OFF_ENABLE, 1'b1, 32'd0);
    rd_chk("rsvd_read", OFF_RSVD, 32'h0);

    // Reset while a completion is in flight
    wr(OFF_ENABLE, 32'h3);
    wr(OFF_SW_SET, 32'h3);
    rd_chk("rst_claim", OFF_CLAIM, 32'h1);
    check("rst_irq_pre", {31'b0, cpu_irq}, 32'h1);
    mem_addr  = BASE + OFF_COMPLETE;
    mem_wdata = 32'h1;
    mem_wstrb = 4'hF;
    mem_valid = 1'b1;
    resetn    = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready", {31'b0, mem_ready}, 32'h0);
    check("mid_rst_eoi",   {24'b0, eoi}, 32'h0);
    check("mid_rst_irq",   {31'b0, cpu_irq}, 32'h0);
    check("mid_rst_rdata", mem_rdata, 32'h0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check("mid_rst_eoi2", {24'b0, eoi}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_insvc",   OFF_INSVC,   32'h0);
    rd_chk("post_rst_pending", OFF_PENDING, 32'h0);
    rd_chk("post_rst_enable",  OFF_ENABLE,  32'h0);

    // Byte strobes and bits above NUM_SRC
    begin
      logic [31:0] r;
      logic [NUM_SRC-1:0] e;
      bus(OFF_ENABLE, 32'hFFFF_FFFF, 4'b0010, r, e);
      rd_chk("wstrb_upper", OFF_ENABLE, 32'h0);
      bus(OFF_ENABLE, 32'h0000_00A5, 4'b0001, r, e);
      rd_chk("wstrb_lane0", OFF_ENABLE, 32'hA5);
      bus(OFF_ENABLE, 32'hFFFF_FFFF, 4'hF, r, e);
      rd_chk("wide_write", OFF_ENABLE, 32'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
